// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding imem request, holds the fetched word until decode retires it.
// Latency: request accepted at N, response at N+1, instr_valid at N+2; retire at M re-requests at M+1.
// Backpressure: request and address stay stable while imem_ready=0; Instr and PC stay stable until dec_ready.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        PCsrc,
    input  logic        reg_jump,
    input  logic [31:0] ImmExt,
    input  logic [31:0] ALUresult,
    input  logic        dec_ready,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] Instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        instr_vld_q;
    logic        req_q;
    logic        err_q;

    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] jalr_target;
    logic [31:0] next_pc;
    logic        next_misaligned;

    assign pc_plus4      = pc_q + 32'd4;
    assign branch_target = pc_q + ImmExt;
    assign jalr_target   = ALUresult & ~32'h0000_0001;

    always_comb begin
        next_pc = pc_plus4;
        if (PCsrc) begin
            next_pc = reg_jump ? jalr_target : branch_target;
        end
    end

    assign next_misaligned = (next_pc[1:0] != 2'b00);

    // req_q comes out of reset low and rises on the first edge, so a
    // handshake only counts once the request is actually visible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FETCH;
            pc_q        <= RESET_PC;
            instr_q     <= NOP_INSTR;
            instr_vld_q <= 1'b0;
            req_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (req_q && imem_ready) begin
                        req_q <= 1'b0;
                        state <= WAIT;
                    end else begin
                        req_q <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        instr_q     <= imem_rdata;
                        instr_vld_q <= 1'b1;
                        state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (dec_ready) begin
                        instr_vld_q <= 1'b0;
                        instr_q     <= NOP_INSTR;
                        if (next_misaligned) begin
                            err_q <= 1'b1;
                            state <= ERR;
                        end else begin
                            pc_q  <= next_pc;
                            req_q <= 1'b1;
                            state <= FETCH;
                        end
                    end
                end
                ERR: begin
                    req_q       <= 1'b0;
                    instr_vld_q <= 1'b0;
                    instr_q     <= NOP_INSTR;
                end
                default: begin
                    state <= FETCH;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign Instr       = instr_q;
    assign instr_valid = instr_vld_q;
    assign fetch_err   = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        PCsrc, reg_jump, dec_ready, imem_ready, imem_rvalid;
    logic [31:0] ImmExt, ALUresult, imem_rdata;
    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, Instr, PC, PCPlus4;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst_n(rst_n), .PCsrc(PCsrc), .reg_jump(reg_jump),
        .ImmExt(ImmExt), .ALUresult(ALUresult), .dec_ready(dec_ready),
        .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .imem_req(imem_req), .imem_addr(imem_addr), .Instr(Instr),
        .instr_valid(instr_valid), .PC(PC), .PCPlus4(PCPlus4), .fetch_err(fetch_err)
    );

    typedef struct {
        logic        pcsrc;
        logic        rj;
        logic [31:0] imm;
        logic [31:0] alu;
        logic [31:0] word;
        int          stall;
        logic [31:0] exp_next;
        logic        exp_err;
    } vec_t;

    vec_t        tbl [11];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] addr_q [$];
    logic [31:0] instr_q [$];
    logic [31:0] cur_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Control inputs carry a misaligned JALR target whenever no retire is happening.
    task automatic drive_idle();
        dec_ready   = 1'b0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        PCsrc       = 1'b1;
        reg_jump    = 1'b1;
        ImmExt      = 32'h0000_0002;
        ALUresult   = 32'h0000_0003;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req"},   imem_req, 1'b0);
        chk({tag, "_valid"}, instr_valid, 1'b0);
        chk({tag, "_instr"}, Instr, NOP);
        chk({tag, "_pc"},    PC, RST_PC);
        chk({tag, "_err"},   fetch_err, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("rst");
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("req_after_release", imem_req, 1'b0);
        addr_q.push_back(RST_PC);
    endtask

    task automatic wait_req(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (imem_req) begin
                seen = 1'b1;
                break;
            end
        end
        chk("req_seen", seen, 1'b1);
        if (seen) begin
            if (addr_q.size() == 0) begin
                chk("addr_sb_nonempty", 32'd0, 32'd1);
            end else begin
                cur_addr = addr_q.pop_front();
                chk("fetch_addr", imem_addr, cur_addr);
                chk("pc_plus4", PCPlus4, cur_addr + 32'd4);
            end
        end
    endtask

    task automatic fetch_one(input logic [31:0] word, input int stall);
        bit seen;
        wait_req(seen);
        if (!seen) return;
        for (int i = 0; i < stall; i++) begin
            imem_rvalid = 1'b1;
            @(negedge clk);
            chk("stall_req", imem_req, 1'b1);
            chk("stall_addr", imem_addr, cur_addr);
            chk("stall_valid", instr_valid, 1'b0);
        end
        imem_rvalid = 1'b0;
        imem_ready  = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("wait_req_low", imem_req, 1'b0);
        chk("wait_valid", instr_valid, 1'b0);
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        instr_q.push_back(word);
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("hold_valid", instr_valid, 1'b1);
        chk("hold_instr", Instr, instr_q.pop_front());
        chk("hold_pc", PC, cur_addr);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0BAD;
        @(negedge clk);
        imem_rvalid = 1'b0;
        chk("hold_stable_instr", Instr, word);
        chk("hold_stable_valid", instr_valid, 1'b1);
    endtask

    task automatic retire(input vec_t v);
        dec_ready = 1'b1;
        PCsrc     = v.pcsrc;
        reg_jump  = v.rj;
        ImmExt    = v.imm;
        ALUresult = v.alu;
        if (!v.exp_err) addr_q.push_back(v.exp_next);
        @(negedge clk);
        drive_idle();
        chk("retire_valid", instr_valid, 1'b0);
        chk("retire_instr", Instr, NOP);
        chk("retire_err", fetch_err, v.exp_err);
        if (!v.exp_err) begin
            chk("retire_req", imem_req, 1'b1);
        end else begin
            chk("err_req", imem_req, 1'b0);
            chk("err_pc", PC, cur_addr);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   seen;
        vec_t v;
        tbl[0]  = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0050_0093, 0, 32'h0000_0004, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0010_0113, 1, 32'h0000_0008, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         32'hFE00_0CE3, 0, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0020_0193, 0, 32'h0000_0004, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0030_0213, 0, 32'h0000_0008, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0040_0293, 2, 32'h0000_000C, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 32'h0,         32'h0000_0105, 32'h0000_80E7, 0, 32'h0000_0104, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         32'h0000_0863, 0, 32'h0000_0114, 1'b0};
        tbl[8]  = '{1'b1, 1'b1, 32'h0,         32'hFFFF_FFFD, 32'h0001_00E7, 0, 32'hFFFF_FFFC, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 32'h0,         32'h0,         32'h0060_0313, 0, 32'h0000_0000, 1'b0};
        tbl[10] = '{1'b1, 1'b1, 32'h0,         32'h0000_0106, 32'h0002_00E7, 0, 32'h0000_0000, 1'b1};

        rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        do_reset();

        for (int i = 0; i < 11; i++) begin
            fetch_one(tbl[i].word, tbl[i].stall);
            retire(tbl[i]);
        end

        // ERR is absorbing: retire strobes and responses must not restart fetching.
        for (int i = 0; i < 4; i++) begin
            dec_ready   = 1'b1;
            imem_rvalid = 1'b1;
            imem_ready  = 1'b1;
            @(negedge clk);
            chk("err_hold_req", imem_req, 1'b0);
            chk("err_hold_flag", fetch_err, 1'b1);
            chk("err_hold_valid", instr_valid, 1'b0);
            chk("err_hold_instr", Instr, NOP);
        end
        drive_idle();

        do_reset();
        fetch_one(32'h0070_0393, 3);
        v = '{1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 0, 32'h0000_0004, 1'b0};
        retire(v);

        // Reset lands while the fetch at 0x4 is waiting for its response.
        wait_req(seen);
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        chk("midwait_req_low", imem_req, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midwait_rst");
        @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD1_BAD1;
        addr_q.push_back(RST_PC);
        @(negedge clk);
        chk("late_rvalid_valid", instr_valid, 1'b0);
        chk("late_rvalid_instr", Instr, NOP);
        chk("post_reset_req", imem_req, 1'b1);
        imem_rvalid = 1'b0;
        fetch_one(32'h00A0_0513, 0);
        retire(v);
        fetch_one(32'h00B0_0593, 0);

        chk("addr_sb_drained", addr_q.size(), 32'd0);
        chk("instr_sb_drained", instr_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, Instr value presented when no fetched instruction exists.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low; releases synchronously to clk.
REQ-005 PCsrc  input  1  redirect request from control, sampled only on the retire cycle.
REQ-006 reg_jump  input  1  redirect is register-based (JALR) when PCsrc=1.
REQ-007 ImmExt  input  32  sign-extended immediate for PC-relative targets.
REQ-008 ALUresult  input  32  computed JALR target.
REQ-009 dec_ready  input  1  downstream consumed the current Instr (retire strobe).
REQ-010 imem_ready  input  1  instruction memory accepts the request this cycle.
REQ-011 imem_rvalid  input  1  imem_rdata valid this cycle.
REQ-012 imem_rdata  input  32  fetched instruction word.
REQ-013 imem_req  output  1  fetch request.
REQ-014 imem_addr  output  32  fetch address, equals PC.
REQ-015 Instr  output  32  instruction to control/decode.
REQ-016 instr_valid  output  1  Instr holds a fetched instruction for the current PC.
REQ-017 PC  output  32  address of Instr.
REQ-018 PCPlus4  output  32  PC+4, modulo 2^32, combinational from PC.
REQ-019 fetch_err  output  1  sticky misaligned-target flag.

Function
REQ-020 FSM states SHALL be FETCH, WAIT, HOLD, ERR.
REQ-021 FETCH: imem_req=1, imem_addr=PC; imem_ready=1 -> WAIT, else stay in FETCH with request and address held stable.
REQ-022 WAIT: imem_req=0; imem_rvalid=1 -> capture imem_rdata into Instr, set instr_valid, go to HOLD; else stay.
REQ-023 imem_rvalid SHALL be ignored in FETCH, HOLD and ERR.
REQ-024 HOLD: instr_valid=1, Instr/PC stable; dec_ready=1 -> load next PC, clear instr_valid, go to FETCH next cycle.
REQ-025 Next PC: PCsrc=1,reg_jump=1 -> {ALUresult[31:1],1'b0}; PCsrc=1,reg_jump=0 -> PC+ImmExt; PCsrc=0 -> PC+4; all adds modulo 2^32, wrap from 32'hFFFF_FFFC to 0 without error.
REQ-026 PCsrc, reg_jump, ImmExt, ALUresult SHALL be sampled only on the HOLD cycle with dec_ready=1; ignored otherwise.
REQ-027 Selected next PC with bits[1:0]!=0 -> PC unchanged, fetch_err=1, go to ERR.
REQ-028 ERR: imem_req=0, instr_valid=0, Instr=NOP_INSTR; left only by reset.
REQ-029 While instr_valid=0, Instr SHALL present NOP_INSTR.
REQ-030 Minimum latency: FETCH with imem_ready=1 at cycle N, imem_rvalid=1 at N+1 -> instr_valid=1 at N+2.
REQ-031 Retire-to-next-request: dec_ready at cycle M -> imem_req=1 with new address at M+1.
REQ-032 At most one outstanding memory request; no new request issued in WAIT.

Reset
REQ-033 rst_n=0 SHALL immediately (no clock) force state=FETCH, PC=RESET_PC, instr_valid=0, Instr=NOP_INSTR, fetch_err=0, imem_req=0.
REQ-034 imem_req SHALL first rise on the first rising clk edge after rst_n deasserts.
REQ-035 Reset asserted in WAIT SHALL discard the pending response; an imem_rvalid arriving after reset in FETCH is ignored.

Verification
REQ-036 Reset then imem_ready=1, rvalid next cycle with 32'h0050_0093 -> imem_addr=0, Instr=32'h0050_0093, instr_valid=1 two cycles after first request.
REQ-037 Retire at PC=0x8 with PCsrc=1,reg_jump=0,ImmExt=32'hFFFF_FFF8 -> next imem_addr=0x0; with PCsrc=0 -> 0xC.
REQ-038 Retire with PCsrc=1,reg_jump=1,ALUresult=32'h0000_0105 -> next imem_addr=0x104; ALUresult=32'h0000_0106 -> fetch_err=1, ERR, imem_req stays 0.
REQ-039 imem_ready=0 for 3 cycles in FETCH -> imem_req=1, imem_addr constant for all 3 cycles; rvalid pulses during FETCH/HOLD ignored.
REQ-040 PC=32'hFFFF_FFFC retire with PCsrc=0 -> next PC=0, fetch_err=0.
REQ-041 rst_n low mid-WAIT -> outputs at reset values before next clk edge; late rvalid ignored; next fetch from RESET_PC.
